// File: rtl/nv_and_tree_pipe.sv
// nv_and_tree_pipe: pipelined N-input AND reduction over LANES independent lanes,
// with a valid pipeline, a global stall (pipe_en) and a per-lane sticky saw-zero flag.
// Optional feature macro: AND_TREE_MASK_EN adds cfg_mask, which forces masked leaves to 1.
// Intermediate stages keep every lane at full WIDTH with the unused upper bits padded
// to 1, so an odd leftover at any tree level simply ANDs with 1.
module nv_and_tree_pipe #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned LANES        = 1,
   parameter int unsigned STAGE_LEVELS = 2
) (
   input  logic                   nvdla_core_clk,
   input  logic                   nvdla_core_rst,
   input  logic                   pipe_en,
   input  logic                   in_vld,
   input  logic [LANES*WIDTH-1:0] in_data,
`ifdef AND_TREE_MASK_EN
   input  logic [WIDTH-1:0]       cfg_mask,
`endif
   input  logic                   sticky_clr,
   output logic                   out_vld,
   output logic [LANES-1:0]       out_z,
   output logic [LANES-1:0]       out_sticky
);

   localparam int unsigned LEVELS  = $clog2(WIDTH);
   localparam int unsigned LAT_RAW = (LEVELS + STAGE_LEVELS - 1) / STAGE_LEVELS;
   localparam int unsigned LAT     = (LAT_RAW < 1) ? 1 : LAT_RAW;
   localparam int unsigned DW      = LANES * WIDTH;

   // Apply n levels of pairwise AND to each lane; results land in the low bits, rest stay 1.
   function automatic logic [DW-1:0] reduce_levels(input logic [DW-1:0] v,
                                                    input int unsigned n);
      logic [DW-1:0]    res;
      logic [WIDTH-1:0] cur;
      logic [WIDTH-1:0] nxt;
      res = '1;
      for (int l = 0; l < int'(LANES); l++) begin
         cur = v[l*WIDTH +: WIDTH];
         for (int unsigned k = 0; k < n; k++) begin
            nxt = '1;
            for (int i = 0; i < int'(WIDTH / 2); i++) begin
               nxt[i] = cur[2*i] & cur[2*i+1];
            end
            if (WIDTH % 2 == 1) begin
               nxt[WIDTH/2] = cur[WIDTH-1];
            end
            cur = nxt;
         end
         res[l*WIDTH +: WIDTH] = cur;
      end
      return res;
   endfunction

   // stg_d/stg_v[s] are the inputs to pipeline stage s (combinational leaves for s=0)
   logic [LAT-1:0][DW-1:0] stg_d;
   logic [LAT-1:0]         stg_v;

   // Leaf formation: optional mask forces selected leaves to 1 in every lane
`ifdef AND_TREE_MASK_EN
   assign stg_d[0] = in_data | {LANES{cfg_mask}};
`else
   assign stg_d[0] = in_data;
`endif
   assign stg_v[0] = in_vld;

   for (genvar s = 0; s < int'(LAT); s++) begin : g_stg
      if (s + 1 < int'(LAT)) begin : g_mid
         logic [DW-1:0] data_q;
         logic          vld_q;

         // Intermediate stage: STAGE_LEVELS tree levels, then register; holds on stall
         always_ff @(posedge nvdla_core_clk) begin
            if (nvdla_core_rst) begin
               data_q <= '0;
               vld_q  <= 1'b0;
            end else if (pipe_en) begin
               data_q <= reduce_levels(stg_d[s], STAGE_LEVELS);
               vld_q  <= stg_v[s];
            end
         end

         assign stg_d[s+1] = data_q;
         assign stg_v[s+1] = vld_q;
      end else begin : g_last
         logic [LANES-1:0] z_c;

         // Remaining levels: a full AND of the padded lane equals the rest of the tree
         always_comb begin
            z_c = '0;
            for (int l = 0; l < int'(LANES); l++) begin
               z_c[l] = &stg_d[s][l*WIDTH +: WIDTH];
            end
         end

         // Final output register; holds on stall
         always_ff @(posedge nvdla_core_clk) begin
            if (nvdla_core_rst) begin
               out_vld <= 1'b0;
               out_z   <= '0;
            end else if (pipe_en) begin
               out_vld <= stg_v[s];
               out_z   <= z_c;
            end
         end
      end
   end

   logic [LANES-1:0] sticky_set_c;
   assign sticky_set_c = {LANES{pipe_en & out_vld}} & ~out_z;

   // Sticky saw-zero: set on an advancing edge past a valid zero; clear works while stalled; set wins
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         out_sticky <= '0;
      end else begin
         out_sticky <= sticky_set_c | (sticky_clr ? '0 : out_sticky);
      end
   end

endmodule

// File: tb/tb_nv_and_tree_pipe.sv
// Bench for nv_and_tree_pipe (WIDTH=8, LANES=2, STAGE_LEVELS=2, latency 2).
// Reference model: a beat's lane result is "all eight bits (OR mask) are ones"; a result
// becomes visible once the pipeline has advanced LAT times since the beat was accepted.
module tb_nv_and_tree_pipe;

   localparam int unsigned LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_en;
   logic        in_vld;
   logic [15:0] in_data;
   logic        sticky_clr;
   logic [7:0]  mask_v;
   logic        out_vld;
   logic [1:0]  out_z;
   logic [1:0]  out_sticky;

   int total = 0;
   int bad   = 0;

   // model state: every accepted (advancing-edge) beat, in order
   bit         vq[$];
   logic [1:0] zq[$];
   logic       e_vld;
   logic [1:0] e_z;
   logic [1:0] e_st;

   nv_and_tree_pipe #(
      .WIDTH(8),
      .LANES(2),
      .STAGE_LEVELS(2)
   ) dut (
      .nvdla_core_clk(clk),
      .nvdla_core_rst(rst),
      .pipe_en(pipe_en),
      .in_vld(in_vld),
      .in_data(in_data),
`ifdef AND_TREE_MASK_EN
      .cfg_mask(mask_v),
`endif
      .sticky_clr(sticky_clr),
      .out_vld(out_vld),
      .out_z(out_z),
      .out_sticky(out_sticky)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] ref_z(input logic [15:0] d, input logic [7:0] m);
      logic [1:0] r;
      for (int l = 0; l < 2; l++) r[l] = ((d[l*8 +: 8] | m) == 8'hFF);
      return r;
   endfunction

   // lanes are mostly all-ones or all-ones-but-one-bit so both results are common
   function automatic logic [15:0] rnd_data();
      logic [15:0] d;
      for (int l = 0; l < 2; l++) begin
         if ($urandom_range(0, 1) == 1) d[l*8 +: 8] = 8'hFF;
         else d[l*8 +: 8] = ~(8'd1 << $urandom_range(0, 7));
      end
      return d;
   endfunction

   // drive one cycle, advance the model at the edge, settle 1 time unit after it
   task automatic step(input logic r, input logic en, input logic v,
                       input logic [15:0] d, input logic c);
      logic [1:0] nst;
      rst = r; pipe_en = en; in_vld = v; in_data = d; sticky_clr = c;
      @(posedge clk);
      if (r) begin
         vq.delete(); zq.delete();
         e_vld = 1'b0; e_z = 2'b00; e_st = 2'b00;
      end else begin
         nst = c ? 2'b00 : e_st;
         if (en && e_vld) nst = nst | ~e_z;
         if (en) begin
            vq.push_back(v);
            zq.push_back(ref_z(d, mask_v));
            if (vq.size() >= LAT) begin
               e_vld = vq[vq.size() - LAT];
               e_z   = zq[zq.size() - LAT];
            end else begin
               e_vld = 1'b0;
            end
         end
         e_st = nst;
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0);
         total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL reset_vld cyc%0d: got %b want 0", i, out_vld); end
         total++; if (out_z !== 2'b00) begin bad++; $display("FAIL reset_z cyc%0d: got %b want 00", i, out_z); end
         total++; if (out_sticky !== 2'b00) begin bad++; $display("FAIL reset_sticky cyc%0d: got %b want 00", i, out_sticky); end
      end
      step(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
      total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL post_reset_early_vld: got %b want 0", out_vld); end
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      total++; if (out_vld !== 1'b1) begin bad++; $display("FAIL post_reset_vld: got %b want 1", out_vld); end
      total++; if (out_z !== 2'b11) begin bad++; $display("FAIL post_reset_z: got %b want 11", out_z); end
      // reset with a zero beat in flight: it must never emerge
      step(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
      step(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
         total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL midreset_vld cyc%0d: got %b want 0", i, out_vld); end
         total++; if (out_sticky !== 2'b00) begin bad++; $display("FAIL midreset_sticky cyc%0d: got %b want 00", i, out_sticky); end
      end
   endtask

   task automatic test_latency();
      step(1'b0, 1'b1, 1'b1, 16'hFF7F, 1'b0);
      total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL lat_early_vld: got %b want 0", out_vld); end
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      total++; if (out_vld !== 1'b1) begin bad++; $display("FAIL lat_vld: got %b want 1", out_vld); end
      total++; if (out_z !== 2'b10) begin bad++; $display("FAIL lat_z: got %b want 10", out_z); end
      total++; if (out_sticky !== 2'b00) begin bad++; $display("FAIL lat_sticky_early: got %b want 00", out_sticky); end
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      total++; if (out_sticky !== 2'b01) begin bad++; $display("FAIL lat_sticky: got %b want 01", out_sticky); end
      total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL lat_vld_drop: got %b want 0", out_vld); end
   endtask

   task automatic test_stall();
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
      total++; if (out_sticky !== 2'b00) begin bad++; $display("FAIL stall_clr: got %b want 00", out_sticky); end
      step(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1, 16'($urandom), 1'b0);
         total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL stall_frozen_vld cyc%0d: got %b want 0", i, out_vld); end
      end
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      total++; if (out_vld !== 1'b1) begin bad++; $display("FAIL stall_resume_vld: got %b want 1", out_vld); end
      total++; if (out_z !== 2'b11) begin bad++; $display("FAIL stall_resume_z: got %b want 11", out_z); end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
         total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL stall_dropped_vld cyc%0d: got %b want 0", i, out_vld); end
      end
      // stall while a valid zero result is showing: output holds, sticky waits for an advance
      step(1'b0, 1'b1, 1'b1, 16'h00FF, 1'b0);
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
         total++; if (out_vld !== 1'b1 || out_z !== 2'b01) begin bad++; $display("FAIL stall_hold cyc%0d: got vld=%b z=%b want vld=1 z=01", i, out_vld, out_z); end
         total++; if (out_sticky !== 2'b00) begin bad++; $display("FAIL stall_sticky_hold cyc%0d: got %b want 00", i, out_sticky); end
      end
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      total++; if (out_sticky !== 2'b10) begin bad++; $display("FAIL stall_sticky_resume: got %b want 10", out_sticky); end
   endtask

   task automatic test_sticky();
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
      total++; if (out_sticky !== 2'b00) begin bad++; $display("FAIL sticky_clear0: got %b want 00", out_sticky); end
      step(1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b0);
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      total++; if (out_vld !== 1'b1 || out_z !== 2'b01) begin bad++; $display("FAIL sticky_src: got vld=%b z=%b want vld=1 z=01", out_vld, out_z); end
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
      total++; if (out_sticky !== 2'b10) begin bad++; $display("FAIL sticky_set_wins: got %b want 10", out_sticky); end
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1);
      total++; if (out_sticky !== 2'b00) begin bad++; $display("FAIL sticky_clear: got %b want 00", out_sticky); end
      step(1'b0, 1'b1, 1'b1, 16'hFF00, 1'b0);
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      total++; if (out_sticky !== 2'b01) begin bad++; $display("FAIL sticky_lane0: got %b want 01", out_sticky); end
      step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      total++; if (out_sticky !== 2'b00) begin bad++; $display("FAIL sticky_clear_stalled: got %b want 00", out_sticky); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 1'b1, rnd_data(), 1'b0);
         if (i > 0) begin
            total++; if (out_vld !== 1'b1) begin bad++; $display("FAIL b2b_vld beat%0d: got %b want 1", i, out_vld); end
         end
         if (e_vld) begin
            total++; if (out_z !== e_z) begin bad++; $display("FAIL b2b_z beat%0d: got %b want %b", i, out_z, e_z); end
         end
         total++; if (out_sticky !== e_st) begin bad++; $display("FAIL b2b_sticky beat%0d: got %b want %b", i, out_sticky, e_st); end
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
         total++; if (out_vld !== e_vld) begin bad++; $display("FAIL b2b_drain_vld cyc%0d: got %b want %b", i, out_vld, e_vld); end
         if (e_vld) begin
            total++; if (out_z !== e_z) begin bad++; $display("FAIL b2b_drain_z cyc%0d: got %b want %b", i, out_z, e_z); end
         end
      end
   endtask

   task automatic test_random();
      logic en, v, c;
      for (int i = 0; i < 80; i++) begin
         en = ($urandom_range(0, 3) != 0);
         v  = ($urandom_range(0, 2) != 0);
         c  = ($urandom_range(0, 9) == 0);
         step(1'b0, en, v, rnd_data(), c);
         total++; if (out_vld !== e_vld) begin bad++; $display("FAIL rnd_vld cyc%0d: got %b want %b", i, out_vld, e_vld); end
         if (e_vld) begin
            total++; if (out_z !== e_z) begin bad++; $display("FAIL rnd_z cyc%0d: got %b want %b", i, out_z, e_z); end
         end
         total++; if (out_sticky !== e_st) begin bad++; $display("FAIL rnd_sticky cyc%0d: got %b want %b", i, out_sticky, e_st); end
      end
   endtask

`ifdef AND_TREE_MASK_EN
   task automatic test_mask();
      mask_v = 8'h80;
      step(1'b0, 1'b1, 1'b1, 16'h7F7F, 1'b0);
      mask_v = 8'h00;
      step(1'b0, 1'b1, 1'b1, 16'h7F7F, 1'b0);
      total++; if (out_vld !== 1'b1 || out_z !== 2'b11) begin bad++; $display("FAIL mask_80: got vld=%b z=%b want vld=1 z=11", out_vld, out_z); end
      mask_v = 8'hFF;
      step(1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
      total++; if (out_vld !== 1'b1 || out_z !== 2'b00) begin bad++; $display("FAIL mask_00: got vld=%b z=%b want vld=1 z=00", out_vld, out_z); end
      mask_v = 8'h00;
      step(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
      total++; if (out_vld !== 1'b1 || out_z !== 2'b11) begin bad++; $display("FAIL mask_ff: got vld=%b z=%b want vld=1 z=11", out_vld, out_z); end
   endtask
`endif

   initial begin
      rst = 1'b1; pipe_en = 1'b0; in_vld = 1'b0; in_data = '0; sticky_clr = 1'b0; mask_v = 8'h00;
      e_vld = 1'b0; e_z = 2'b00; e_st = 2'b00;
      test_reset();
      test_latency();
      test_stall();
      test_sticky();
      test_back_to_back();
`ifdef AND_TREE_MASK_EN
      test_mask();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
